// File: rtl/pll_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pll_seq_ctrl
//
// PLL start-up and supervision sequencer running from the boot oscillator.
// It enables the PLL, waits for lock with a timeout, lets lock settle, then
// hands the glitch-free clock mux to the PLL.  On lock loss or a dropped
// request it moves the mux back to the oscillator first, waits a guard
// interval, and only then disables the PLL.  Failed attempts are retried up
// to MAX_RETRY times before a fault is latched.
//
// Ports:
//   clk        boot oscillator clock
//   rst_n      asynchronous active-low reset
//   en_req     level request: PLL clock wanted
//   pll_lock   PLL lock indication, asynchronous to clk
//   pll_en     PLL enable
//   clk_sel    mux select (0 = oscillator, 1 = PLL)
//   ready      PLL clock selected and stable
//   fault      retry limit exhausted
//   state      current state encoding
//   retry_cnt  failed attempts since the last RUN or IDLE
// ---------------------------------------------------------------------------
module pll_seq_ctrl #(
    parameter int LOCK_TIMEOUT  = 1000,
    parameter int SETTLE_CYCLES = 64,
    parameter int GUARD_CYCLES  = 4,
    parameter int OFF_CYCLES    = 16,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_req,
    input  logic       pll_lock,
    output logic       pll_en,
    output logic       clk_sel,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt
);

    // The single cycle counter must hold the largest interval minus one.
    localparam int MAX_AB  = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_CD  = (GUARD_CYCLES > OFF_CYCLES) ? GUARD_CYCLES : OFF_CYCLES;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENABLE = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_OFF    = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t           cur;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             lock_s;
    logic [3:0]       out_q;
    logic [3:0]       retry_inc;

    // Output bundle for a state: {pll_en, clk_sel, ready, fault}.  It is
    // loaded together with the state so the outputs are registered and
    // change on the same edge as the state.
    function automatic logic [3:0] decode(input state_t s);
        logic [3:0] o;
        o = 4'b0000;
        case (s)
            S_ENABLE, S_SETTLE, S_DRAIN: o = 4'b1000;
            S_RUN:                       o = 4'b1110;
            S_FAULT:                     o = 4'b0001;
            default:                     o = 4'b0000;
        endcase
        return o;
    endfunction

    assign retry_inc = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;

    assign pll_en  = out_q[3];
    assign clk_sel = out_q[2];
    assign ready   = out_q[1];
    assign fault   = out_q[0];
    assign state   = cur;

    // Two-flop synchronizer for the asynchronous lock indication; only
    // lock_s is used by the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    // Sequencer.  Every timed state starts with the counter at zero and
    // leaves when it reaches its interval minus one, so each state lasts
    // exactly its interval.  A failure is checked before a request drop so
    // a coincident drop still counts the failed attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_IDLE;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            out_q     <= 4'b0000;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (en_req) begin
                        cur   <= S_ENABLE;
                        out_q <= decode(S_ENABLE);
                        cnt   <= '0;
                    end
                end

                S_ENABLE: begin
                    if (!lock_s && cnt == TIMEOUT_LAST) begin
                        cur       <= S_DRAIN;
                        out_q     <= decode(S_DRAIN);
                        cnt       <= '0;
                        retry_cnt <= retry_inc;
                    end else if (!en_req) begin
                        cur   <= S_DRAIN;
                        out_q <= decode(S_DRAIN);
                        cnt   <= '0;
                    end else if (lock_s) begin
                        cur   <= S_SETTLE;
                        out_q <= decode(S_SETTLE);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SETTLE: begin
                    if (!lock_s) begin
                        cur       <= S_DRAIN;
                        out_q     <= decode(S_DRAIN);
                        cnt       <= '0;
                        retry_cnt <= retry_inc;
                    end else if (!en_req) begin
                        cur   <= S_DRAIN;
                        out_q <= decode(S_DRAIN);
                        cnt   <= '0;
                    end else if (cnt == SETTLE_LAST) begin
                        cur       <= S_RUN;
                        out_q     <= decode(S_RUN);
                        cnt       <= '0;
                        retry_cnt <= 4'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (!lock_s) begin
                        cur       <= S_DRAIN;
                        out_q     <= decode(S_DRAIN);
                        cnt       <= '0;
                        retry_cnt <= retry_inc;
                    end else if (!en_req) begin
                        cur   <= S_DRAIN;
                        out_q <= decode(S_DRAIN);
                        cnt   <= '0;
                    end
                end

                // Mux is already back on the oscillator; keep the PLL
                // running until the mux has safely switched over.
                S_DRAIN: begin
                    if (cnt == GUARD_LAST) begin
                        cur   <= S_OFF;
                        out_q <= decode(S_OFF);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_OFF: begin
                    if (cnt == OFF_LAST) begin
                        cnt <= '0;
                        if (retry_cnt == RETRY_LIMIT) begin
                            cur   <= S_FAULT;
                            out_q <= decode(S_FAULT);
                        end else if (en_req) begin
                            cur   <= S_ENABLE;
                            out_q <= decode(S_ENABLE);
                        end else begin
                            cur       <= S_IDLE;
                            out_q     <= decode(S_IDLE);
                            retry_cnt <= 4'd0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_FAULT: begin
                    if (!en_req) begin
                        cur       <= S_IDLE;
                        out_q     <= decode(S_IDLE);
                        cnt       <= '0;
                        retry_cnt <= 4'd0;
                    end
                end

                default: begin
                    cur       <= S_IDLE;
                    out_q     <= decode(S_IDLE);
                    cnt       <= '0;
                    retry_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_seq_ctrl.md
# pll_seq_ctrl

PLL start-up and supervision sequencer, clocked from the always-running boot oscillator. It drives the PLL enable and waits for lock with a timeout. Once lock has been stable for a settle interval, it hands the downstream glitch-free clock mux over to the PLL output. On lock loss or an enable drop it moves the mux back to the oscillator before disabling the PLL, and it retries failed lock attempts up to a limit before latching a fault.

## Interface

Parameters:
- LOCK_TIMEOUT, 1000: max boot-clock cycles in ENABLE waiting for lock
- SETTLE_CYCLES, 64: consecutive locked cycles required before RUN
- GUARD_CYCLES, 4: cycles with clk_sel low before pll_en drops
- OFF_CYCLES, 16: minimum cycles pll_en stays low between attempts
- MAX_RETRY, 3: consecutive failed attempts before FAULT (1..15)

Ports:
- clk  in  1  boot oscillator clock
- rst_n  in  1  asynchronous active-low reset
- en_req  in  1  level request: PLL clock wanted
- pll_lock  in  1  PLL lock, asynchronous to clk
- pll_en  out  1  PLL enable
- clk_sel  out  1  mux select: 0 = oscillator, 1 = PLL
- ready  out  1  PLL clock selected and stable
- fault  out  1  retry limit exhausted
- state  out  3  current state encoding
- retry_cnt  out  4  failed attempts since last RUN or IDLE

## Operation

- pll_lock passes through a 2-flop synchronizer; lock_s is the second flop. All decisions use lock_s.
- State encoding: IDLE=0, ENABLE=1, SETTLE=2, RUN=3, DRAIN=4, OFF=5, FAULT=6.
- Outputs are registered and decoded from the state:
  - pll_en=1 in ENABLE, SETTLE, RUN, DRAIN.
  - clk_sel=1 and ready=1 in RUN only.
  - fault=1 in FAULT only.
- IDLE: if en_req=1, go to ENABLE; the cycle counter is cleared.
- ENABLE:
  - lock_s=1 goes to SETTLE with the counter cleared.
  - Otherwise the counter increments. When it reaches LOCK_TIMEOUT-1 without lock, this is a failure.
- SETTLE:
  - The counter increments while lock_s=1. When it reaches SETTLE_CYCLES-1, go to RUN and clear retry_cnt.
  - lock_s=0 is a failure.
- RUN: lock_s=0 is a failure.
- Failure handling: retry_cnt increments (saturating at 15) and the state goes to DRAIN.
- en_req=0 in ENABLE, SETTLE or RUN goes to DRAIN without a failure. retry_cnt is cleared on the following IDLE entry.
- DRAIN: clk_sel=0 and pll_en=1 held for GUARD_CYCLES cycles, then OFF.
- OFF: pll_en=0 held for OFF_CYCLES cycles. Then:
  - retry_cnt==MAX_RETRY goes to FAULT;
  - otherwise en_req=1 goes to ENABLE;
  - otherwise IDLE, with retry_cnt cleared.
- FAULT: everything is held off. en_req=0 returns to IDLE with retry_cnt cleared.
- Priority when events coincide:
  - In the same cycle: failure beats en_req drop (the retry is counted).
  - In ENABLE: lock_s=1 beats a timeout.
  - In SETTLE: lock_s=0 beats settle completion.
- Invariants:
  - clk_sel never rises while pll_en=0.
  - pll_en never falls while clk_sel=1 or within GUARD_CYCLES of clk_sel falling.

## Timing

- Reset: async assert forces IDLE, counters cleared, synchronizer cleared, all outputs 0. Deassertion is taken synchronously at the next clk edge.
- en_req sampled high at edge N gives state=ENABLE and pll_en=1 after edge N.
- pll_lock rising before edge M makes lock_s high after edge M+1. State becomes SETTLE after edge M+2.
- ready and clk_sel rise exactly SETTLE_CYCLES edges after the SETTLE entry edge.
- Lock loss in RUN: clk_sel and ready fall 3 edges after pll_lock falls (2 synchronizer edges plus 1 state edge). pll_en falls GUARD_CYCLES edges later.
- Total off time of pll_en between attempts: exactly OFF_CYCLES cycles.
- Counter width: $clog2 of the maximum of the cycle parameters, plus 1. No wrap is possible.

## Test plan

Each scenario runs with LOCK_TIMEOUT=100, SETTLE_CYCLES=16, GUARD_CYCLES=4, OFF_CYCLES=8, MAX_RETRY=2.

- Clean start: en_req=1, pll_lock rises 20 cycles later → SETTLE 2 cycles after lock, ready=1 and clk_sel=1 16 cycles after that, retry_cnt=0.
- Lock glitch in SETTLE: pll_lock low for 3 cycles at settle count 10 → DRAIN, retry_cnt=1, pll_en low for 8 cycles, ENABLE again, RUN after relock.
- Timeout to fault: pll_lock held 0 → two 100-cycle ENABLE windows, each followed by 4 DRAIN + 8 OFF cycles, then state=6 and fault=1. en_req=0 → IDLE, fault=0, retry_cnt=0.
- Lock loss in RUN: pll_lock drops → clk_sel falls 3 cycles later, pll_en falls 4 cycles after that; the checker asserts the invariants on every cycle.
- Request withdrawal: en_req=0 in RUN → DRAIN, OFF, IDLE with retry_cnt unchanged in DRAIN and cleared in IDLE. Simultaneous en_req=0 and lock loss → retry_cnt increments.
- Reset mid-operation: rst_n asserted in RUN → all outputs 0 immediately, without waiting for a clock edge. Restart after release → clean-start behaviour.
